// File: rtl/wb_grf_if.sv
// wb_grf_if -- bundles the write-back stage inputs, the D-stage read
// addresses and the register-file results that pass between the pipeline
// and the general register file. The clock and reset are not part of the
// bundle.
//
// Signals (master = pipeline side, slave = register file side):
//   Instr_W  [31:0]  instruction word held in the W stage
//   A3W      [4:0]   destination register, 0 = no write
//   PC_W     [31:0]  PC of the W-stage instruction
//   ALUoutW  [31:0]  ALU result, or memory address for loads
//   DMreadW  [31:0]  raw aligned data-memory word
//   A1, A2   [4:0]   read addresses from the D stage
//   RD1, RD2 [31:0]  read data
//   WD_W     [31:0]  final write-back data, exported for forwarding
//   WE_W             write enable, exported for forwarding
interface wb_grf_if;
  logic [31:0] Instr_W;
  logic [4:0]  A3W;
  logic [31:0] PC_W;
  logic [31:0] ALUoutW;
  logic [31:0] DMreadW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WD_W;
  logic        WE_W;

  modport master (
    output Instr_W, A3W, PC_W, ALUoutW, DMreadW, A1, A2,
    input  RD1, RD2, WD_W, WE_W
  );

  modport slave (
    input  Instr_W, A3W, PC_W, ALUoutW, DMreadW, A1, A2,
    output RD1, RD2, WD_W, WE_W
  );
endinterface

// File: rtl/wb_grf.sv
// wb_grf -- write-back data selection plus the 32 x 32-bit general register
// file. Load results are extracted from the raw memory word, jal/jalr
// link addresses are formed as PC + 8, and everything else writes the
// ALU result. Register 0 always reads 0 and is never written.
//
// Ports:
//   Clk    rising-edge clock for all state
//   Reset  synchronous, active-high; clears every register, beats a write
//   bus    wb_grf_if.slave -- W-stage inputs, read addresses, RD1/RD2,
//          and the combinational WD_W/WE_W exported for forwarding
//
// Build option:
//   GRF_BYPASS_EN  when defined, a read of the register being written this
//                  cycle returns WD_W instead of the stored value.
module wb_grf (
  input  logic     Clk,
  input  logic     Reset,
  wb_grf_if.slave  bus
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  // Write-back data selection from opcode/funct, address low bits and memory word.
  function automatic logic [31:0] wb_select(
    input logic [5:0]  op,
    input logic [5:0]  funct,
    input logic [31:0] alu,
    input logic [31:0] dm,
    input logic [31:0] pc
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (alu[1:0])
      2'b00:   byte_v = dm[7:0];
      2'b01:   byte_v = dm[15:8];
      2'b10:   byte_v = dm[23:16];
      2'b11:   byte_v = dm[31:24];
      default: byte_v = 8'h00;
    endcase
    // Halfword loads take the upper half when bit 1 is set; bit 0 is ignored.
    half_v = alu[1] ? dm[31:16] : dm[15:0];
    case (op)
      OP_LW:   res_v = dm;
      OP_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  res_v = {24'h000000, byte_v};
      OP_LH:   res_v = {{16{half_v[15]}}, half_v};
      OP_LHU:  res_v = {16'h0000, half_v};
      OP_JAL:  res_v = pc + 32'd8;
      OP_SPECIAL: begin
        if (funct == FN_JALR) begin
          res_v = pc + 32'd8;
        end else begin
          res_v = alu;
        end
      end
      default: res_v = alu;
    endcase
    return res_v;
  endfunction

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] wd_s;
  logic        we_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic        unused_instr_bits_s;

  // Only the opcode and funct fields of the instruction matter here.
  assign unused_instr_bits_s = ^bus.Instr_W[25:6];

  // Write-back data and enable, combinational so forwarding sees them this cycle.
  always_comb begin
    wd_s = wb_select(bus.Instr_W[31:26], bus.Instr_W[5:0],
                     bus.ALUoutW, bus.DMreadW, bus.PC_W);
    we_s = (bus.A3W != 5'd0);
  end

  // Next register contents: reset clears all, else one addressed register updates.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < 32; i++) begin
      if (i == 0) begin
        regs_d[i] = 32'h0000_0000;
      end else if (Reset) begin
        regs_d[i] = 32'h0000_0000;
      end else if (we_s && (bus.A3W == 5'(i))) begin
        regs_d[i] = wd_s;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register array state.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 32; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Read port 1: address 0 is hard-wired to zero.
  always_comb begin
    rd1_s = 32'h0000_0000;
    if (bus.A1 == 5'd0) begin
      rd1_s = 32'h0000_0000;
`ifdef GRF_BYPASS_EN
    end else if (we_s && (bus.A1 == bus.A3W)) begin
      rd1_s = wd_s;
`endif
    end else begin
      rd1_s = regs_q[bus.A1];
    end
  end

  // Read port 2: address 0 is hard-wired to zero.
  always_comb begin
    rd2_s = 32'h0000_0000;
    if (bus.A2 == 5'd0) begin
      rd2_s = 32'h0000_0000;
`ifdef GRF_BYPASS_EN
    end else if (we_s && (bus.A2 == bus.A3W)) begin
      rd2_s = wd_s;
`endif
    end else begin
      rd2_s = regs_q[bus.A2];
    end
  end

  assign bus.WD_W = wd_s;
  assign bus.WE_W = we_s;
  assign bus.RD1  = rd1_s;
  assign bus.RD2  = rd2_s;

endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf -- self-checking bench for wb_grf: directed cases with fixed
// expected values, then randomized cycles checked against a reference model
// (an array of 32 words plus the load/link arithmetic written out directly).
module tb_wb_grf;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  logic [31:0] mregs [32];

  wb_grf_if bus_if ();

  wb_grf dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] funct);
    return {op, 20'h00000, funct};
  endfunction

  // Expected write-back value computed from the instruction rules with plain arithmetic.
  function automatic logic [31:0] exp_wd(input logic [31:0] instr, input logic [31:0] alu,
                                         input logic [31:0] dm, input logic [31:0] pc);
    logic [31:0] op, funct, b, byte_v, half_v;
    op     = instr >> 26;
    funct  = instr & 32'd63;
    b      = alu % 32'd4;
    byte_v = (dm >> (32'd8 * b)) & 32'd255;
    half_v = ((alu & 32'd2) != 32'd0) ? (dm >> 16) : (dm & 32'd65535);
    if (op == 32'd35) return dm;
    if (op == 32'd32) return (byte_v >= 32'd128) ? (byte_v | 32'hFFFF_FF00) : byte_v;
    if (op == 32'd36) return byte_v;
    if (op == 32'd33) return (half_v >= 32'd32768) ? (half_v | 32'hFFFF_0000) : half_v;
    if (op == 32'd37) return half_v;
    if (op == 32'd3 || (op == 32'd0 && funct == 32'd9)) return pc + 32'd8;
    return alu;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] addr);
    logic [31:0] wd;
    wd = exp_wd(bus_if.Instr_W, bus_if.ALUoutW, bus_if.DMreadW, bus_if.PC_W);
    if (addr == 5'd0) return 32'h0;
`ifdef GRF_BYPASS_EN
    if (bus_if.A3W != 5'd0 && addr == bus_if.A3W) return wd;
`endif
    return mregs[addr];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] instr, input logic [4:0] a3, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus_if.Instr_W = instr;
    bus_if.A3W     = a3;
    bus_if.PC_W    = pc;
    bus_if.ALUoutW = alu;
    bus_if.DMreadW = dm;
    bus_if.A1      = a1;
    bus_if.A2      = a2;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".we"},  {31'd0, bus_if.WE_W}, {31'd0, (bus_if.A3W != 5'd0)});
    check({tag, ".wd"},  bus_if.WD_W, exp_wd(bus_if.Instr_W, bus_if.ALUoutW, bus_if.DMreadW, bus_if.PC_W));
    check({tag, ".rd1"}, bus_if.RD1, exp_rd(bus_if.A1));
    check({tag, ".rd2"}, bus_if.RD2, exp_rd(bus_if.A2));
  endtask

  // One clock edge; the model follows the write/reset rules at that edge.
  task automatic tick();
    logic [31:0] wd;
    wd = exp_wd(bus_if.Instr_W, bus_if.ALUoutW, bus_if.DMreadW, bus_if.PC_W);
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    end else if (bus_if.A3W != 5'd0) begin
      mregs[bus_if.A3W] = wd;
    end
    @(negedge Clk);
  endtask

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_JAL = 6'b000011;

  initial begin
    logic [31:0] lb_exp [4];
    logic [31:0] instr;
    logic [4:0]  a3, a1, a2;
    total = 0;
    bad   = 0;
    lb_exp[0] = 32'h0000_0001;
    lb_exp[1] = 32'h0000_007F;
    lb_exp[2] = 32'hFFFF_FFFF;
    lb_exp[3] = 32'hFFFF_FF80;

    // Reset for one edge, then every address reads zero.
    Reset = 1'b1;
    apply(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    tick();
    Reset = 1'b0;
    apply(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    check("reset.rd1_a5", bus_if.RD1, 32'h0);
    check("reset.rd2_a31", bus_if.RD2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      apply(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
      check("reset.sweep_rd1", bus_if.RD1, 32'h0);
      check("reset.sweep_rd2", bus_if.RD2, 32'h0);
    end

    // Byte loads at each offset.
    for (int k = 0; k < 4; k++) begin
      apply(mk(OP_LB, 6'd0), 5'd0, 32'h0, 32'h1000 + 32'(k), 32'h80FF_7F01, 5'd0, 5'd0);
      check("lb.offset", bus_if.WD_W, lb_exp[k]);
    end
    apply(mk(OP_LBU, 6'd0), 5'd0, 32'h0, 32'h0000_1003, 32'h80FF_7F01, 5'd0, 5'd0);
    check("lbu.offset3", bus_if.WD_W, 32'h0000_0080);

    // Halfword loads.
    apply(mk(OP_LH, 6'd0), 5'd0, 32'h0, 32'h2, 32'h8001_FFFE, 5'd0, 5'd0);
    check("lh.upper", bus_if.WD_W, 32'hFFFF_8001);
    apply(mk(OP_LHU, 6'd0), 5'd0, 32'h0, 32'h2, 32'h8001_FFFE, 5'd0, 5'd0);
    check("lhu.upper", bus_if.WD_W, 32'h0000_8001);
    apply(mk(OP_LH, 6'd0), 5'd0, 32'h0, 32'h0, 32'h8001_FFFE, 5'd0, 5'd0);
    check("lh.lower", bus_if.WD_W, 32'hFFFF_FFFE);
    apply(mk(OP_LH, 6'd0), 5'd0, 32'h0, 32'h3, 32'h8001_FFFE, 5'd0, 5'd0);
    check("lh.bit0_ignored", bus_if.WD_W, 32'hFFFF_8001);
    apply(mk(OP_LW, 6'd0), 5'd0, 32'h0, 32'h3, 32'h8001_FFFE, 5'd0, 5'd0);
    check("lw.word", bus_if.WD_W, 32'h8001_FFFE);

    // jal links PC+8 into register 31, visible the next cycle.
    apply(mk(OP_JAL, 6'd0), 5'd31, 32'h0000_3000, 32'h55, 32'h0, 5'd0, 5'd0);
    check("jal.wd", bus_if.WD_W, 32'h0000_3008);
    check("jal.we", {31'd0, bus_if.WE_W}, 32'd1);
    tick();
    apply(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd31);
    check("jal.r31_rd1", bus_if.RD1, 32'h0000_3008);
    check("jal.r31_rd2", bus_if.RD2, 32'h0000_3008);

    // jalr wraps modulo 2^32.
    apply(mk(6'd0, 6'b001001), 5'd0, 32'hFFFF_FFFC, 32'h77, 32'h0, 5'd0, 5'd0);
    check("jalr.wrap", bus_if.WD_W, 32'h0000_0004);

    // Destination 0: no write enable and register 0 stays zero.
    apply(mk(6'd0, 6'b100001), 5'd0, 32'h0, 32'h1234_5678, 32'h0, 5'd0, 5'd0);
    check("a3zero.we", {31'd0, bus_if.WE_W}, 32'd0);
    check("a3zero.wd", bus_if.WD_W, 32'h1234_5678);
    tick();
    apply(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    check("a3zero.r0", bus_if.RD1, 32'h0);

    // Same-cycle write and read of register 8.
    apply(mk(6'd0, 6'b100001), 5'd8, 32'h0, 32'h1111_1111, 32'h0, 5'd0, 5'd0);
    tick();
    apply(mk(6'd0, 6'b100001), 5'd8, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd9);
`ifdef GRF_BYPASS_EN
    check("bypass.rd1", bus_if.RD1, 32'hDEAD_BEEF);
`else
    check("bypass.rd1", bus_if.RD1, 32'h1111_1111);
`endif
    check("bypass.rd2_other", bus_if.RD2, 32'h0);
    tick();
    apply(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd31);
    check("after_write.r8", bus_if.RD1, 32'hDEAD_BEEF);
    check("after_write.r31", bus_if.RD2, 32'h0000_3008);

    // Reset wins over a simultaneous write; WE/WD unaffected by Reset.
    Reset = 1'b1;
    apply(mk(6'd0, 6'b100001), 5'd8, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd0, 5'd0);
    check("reset_write.we", {31'd0, bus_if.WE_W}, 32'd1);
    check("reset_write.wd", bus_if.WD_W, 32'hCAFE_F00D);
    tick();
    Reset = 1'b0;
    apply(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd31);
    check("reset_write.r8", bus_if.RD1, 32'h0);
    check("reset_write.r31", bus_if.RD2, 32'h0);

    // Randomized cycles against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 8))
        0: instr = mk(OP_LW, 6'($urandom));
        1: instr = mk(OP_LB, 6'($urandom));
        2: instr = mk(OP_LBU, 6'($urandom));
        3: instr = mk(OP_LH, 6'($urandom));
        4: instr = mk(OP_LHU, 6'($urandom));
        5: instr = mk(OP_JAL, 6'($urandom));
        6: instr = mk(6'd0, 6'b001001) | ($urandom & 32'h03FF_FFC0);
        7: instr = mk(6'd0, 6'($urandom));
        default: instr = $urandom;
      endcase
      a3 = 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom);
      Reset = ($urandom_range(0, 31) == 0);
      apply(instr, a3, $urandom, $urandom, $urandom, a1, a2);
      check_model("rand");
      tick();
    end
    Reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
